mem_wb: RTL and testbench
=========================

MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 SHALL have port clk_100MHz, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port srst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port valid_i, input, 1 bit: MEM-stage instruction valid this cycle.
REQ-004 SHALL have port w_e_i, input, 1 bit: instruction writes rd.
REQ-005 SHALL have port w_addr_i, input, 5 bits: rd index.
REQ-006 SHALL have port alu_data_i, input, 32 bits: non-load result.
REQ-007 SHALL have port is_load_i, input, 1 bit: instruction is a load.
REQ-008 SHALL have port load_funct3_i, input, 3 bits: load type.
REQ-009 SHALL have port load_addr_lo_i, input, 2 bits: load byte offset.
REQ-010 SHALL have port dbus_rvalid_i, input, 1 bit: load data returned this cycle.
REQ-011 SHALL have port dbus_rdata_i, input, 32 bits: aligned load word.
REQ-012 SHALL have port stall_o, output, 1 bit: upstream must hold MEM stage.
REQ-013 SHALL have port w_e_o, output, 1 bit: register-file write enable.
REQ-014 SHALL have port w_addr_o, output, 5 bits: register-file write address.
REQ-015 SHALL have port w_data_o, output, 32 bits: register-file write data.
REQ-016 SHALL have port err_o, output, 1 bit: sticky load-timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE and WAIT; stall_o = (state == WAIT), combinational from state only.
REQ-018 In IDLE with valid_i=1, is_load_i=0: SHALL drive w_e_o = w_e_i & (w_addr_i != 0), w_addr_o = w_addr_i, w_data_o = alu_data_i on the next cycle (latency 1).
REQ-019 In IDLE with valid_i=1, is_load_i=1: SHALL capture w_e_i, w_addr_i, load_funct3_i, load_addr_lo_i and enter WAIT; no write that cycle.
REQ-020 In WAIT: SHALL ignore valid_i; on dbus_rvalid_i=1, SHALL register extracted data to w_data_o, assert w_e_o (subject to REQ-022/023) next cycle, and return to IDLE.
REQ-021 Extraction: 000 LB sign-extends byte[addr_lo]; 100 LBU zero-extends byte[addr_lo]; 001 LH sign-extends half[addr_lo[1]]; 101 LHU zero-extends half[addr_lo[1]]; 010 LW passes the word; addr_lo[0] is ignored for halves.
REQ-022 funct3 011, 110 and 111 SHALL suppress the write (w_e_o=0) and still return to IDLE.
REQ-023 w_e_o SHALL be a one-cycle pulse per retired instruction and SHALL never be asserted for w_addr 0.
REQ-024 dbus_rvalid_i in IDLE SHALL be ignored, including stale responses after reset.
REQ-025 When w_e_o=0, w_addr_o and w_data_o SHALL hold their previous values.

Reset
REQ-026 srst=1 SHALL force state IDLE, w_e_o=0, w_addr_o=0, w_data_o=0, err_o=0 and the timeout counter to 0 on the next edge, overriding all other inputs, including in WAIT.

Configuration
REQ-027 Macro MEM_WB_LOAD_TIMEOUT_EN defined: SHALL use a 4-bit counter cleared on WAIT entry and incremented each WAIT cycle without rvalid.
REQ-028 Under MEM_WB_LOAD_TIMEOUT_EN, the 16th such cycle SHALL abort the load (no write), return to IDLE and set err_o until srst.
REQ-029 Macro MEM_WB_LOAD_TIMEOUT_EN undefined: WAIT SHALL persist indefinitely, err_o SHALL be tied to 0, and no counter logic SHALL be present.

Verification
REQ-030 Bench SHALL cover ALU op: valid=1, w_e=1, rd=5, alu=0x12345678 -> next cycle w_e_o=1, w_addr_o=5, w_data_o=0x12345678, then w_e_o=0.
REQ-031 Bench SHALL cover LB: offset=3, rdata=0x80FFFFFF, rvalid 2 cycles after acceptance -> stall_o high 2 cycles, then w_data_o=0xFFFFFF80; under LBU the same stimulus -> 0x00000080.
REQ-032 Bench SHALL cover LHU: offset=2, rdata=0xBEEF1234 -> w_data_o=0x0000BEEF.
REQ-033 Bench SHALL cover rd=0: ALU op with w_e=1, rd=0 -> w_e_o stays 0; an LW to rd 0 also produces no write.
REQ-034 Bench SHALL cover reset in WAIT: srst pulse, then rvalid -> no write, state IDLE, stall_o=0.
REQ-035 Bench SHALL cover timeout with MEM_WB_LOAD_TIMEOUT_EN defined: no rvalid for 16 cycles -> err_o=1, stall_o=0, no write, and the next ALU op retires normally.

Source files
------------

// File: rtl/mem_wb.sv
// MEM/WB stage: retires ALU results directly and waits for load data, extracting bytes/halves.
// Optional `MEM_WB_LOAD_TIMEOUT_EN aborts a load after 16 cycles without data and sets sticky err_o.
`timescale 1ns/1ps

module mem_wb (
    input  logic        clk_100MHz,
    input  logic        srst,
    input  logic        valid_i,
    input  logic        w_e_i,
    input  logic [4:0]  w_addr_i,
    input  logic [31:0] alu_data_i,
    input  logic        is_load_i,
    input  logic [2:0]  load_funct3_i,
    input  logic [1:0]  load_addr_lo_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        stall_o,
    output logic        w_e_o,
    output logic [4:0]  w_addr_o,
    output logic [31:0] w_data_o,
    output logic        err_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        w_e_q, w_e_d;
    logic [4:0]  w_addr_q, w_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic        ld_we_q, ld_we_d;
    logic [4:0]  ld_addr_q, ld_addr_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  ld_lo_q, ld_lo_d;

    logic        ld_ok;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

`ifdef MEM_WB_LOAD_TIMEOUT_EN
    logic        err_q, err_d;
    logic [3:0]  cnt_q, cnt_d;
`endif

    // Byte lanes follow the captured offset; halves ignore addr_lo[0].
    always_comb begin
        ld_byte = dbus_rdata_i[{ld_lo_q, 3'b000} +: 8];
        ld_half = dbus_rdata_i[{ld_lo_q[1], 4'b0000} +: 16];
        ld_ok   = 1'b1;
        ld_data = '0;
        case (ld_f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            3'b010:  ld_data = dbus_rdata_i;
            default: ld_ok   = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        w_e_d     = 1'b0;
        w_addr_d  = w_addr_q;
        w_data_d  = w_data_q;
        ld_we_d   = ld_we_q;
        ld_addr_d = ld_addr_q;
        ld_f3_d   = ld_f3_q;
        ld_lo_d   = ld_lo_q;
`ifdef MEM_WB_LOAD_TIMEOUT_EN
        err_d     = err_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (is_load_i) begin
                        ld_we_d   = w_e_i;
                        ld_addr_d = w_addr_i;
                        ld_f3_d   = load_funct3_i;
                        ld_lo_d   = load_addr_lo_i;
                        state_d   = ST_WAIT;
`ifdef MEM_WB_LOAD_TIMEOUT_EN
                        cnt_d     = 4'd0;
`endif
                    end else if (w_e_i && (w_addr_i != 5'd0)) begin
                        w_e_d    = 1'b1;
                        w_addr_d = w_addr_i;
                        w_data_d = alu_data_i;
                    end
                end
            end
            ST_WAIT: begin
                if (dbus_rvalid_i) begin
                    state_d = ST_IDLE;
                    if (ld_ok && ld_we_q && (ld_addr_q != 5'd0)) begin
                        w_e_d    = 1'b1;
                        w_addr_d = ld_addr_q;
                        w_data_d = ld_data;
                    end
                end
`ifdef MEM_WB_LOAD_TIMEOUT_EN
                else if (cnt_q == 4'hF) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (srst) begin
            state_q   <= ST_IDLE;
            w_e_q     <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            ld_we_q   <= 1'b0;
            ld_addr_q <= '0;
            ld_f3_q   <= '0;
            ld_lo_q   <= '0;
`ifdef MEM_WB_LOAD_TIMEOUT_EN
            err_q     <= 1'b0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            w_e_q     <= w_e_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
            ld_we_q   <= ld_we_d;
            ld_addr_q <= ld_addr_d;
            ld_f3_q   <= ld_f3_d;
            ld_lo_q   <= ld_lo_d;
`ifdef MEM_WB_LOAD_TIMEOUT_EN
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign stall_o  = (state_q == ST_WAIT);
    assign w_e_o    = w_e_q;
    assign w_addr_o = w_addr_q;
    assign w_data_o = w_data_q;
`ifdef MEM_WB_LOAD_TIMEOUT_EN
    assign err_o    = err_q;
`else
    assign err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: directed cases plus randomized ALU/load mix against a reference model.
`timescale 1ns/1ps

module tb_mem_wb;

    logic        clk_100MHz = 1'b0;
    logic        srst;
    logic        valid_i, w_e_i, is_load_i, dbus_rvalid_i;
    logic [4:0]  w_addr_i;
    logic [31:0] alu_data_i, dbus_rdata_i;
    logic [2:0]  load_funct3_i;
    logic [1:0]  load_addr_lo_i;
    logic        stall_o, w_e_o, err_o;
    logic [4:0]  w_addr_o;
    logic [31:0] w_data_o;

    int checks = 0;
    int errors = 0;

    // Reference view of the register-file port: last written address/data.
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    always #5 clk_100MHz = ~clk_100MHz;

    mem_wb dut (
        .clk_100MHz    (clk_100MHz),
        .srst          (srst),
        .valid_i       (valid_i),
        .w_e_i         (w_e_i),
        .w_addr_i      (w_addr_i),
        .alu_data_i    (alu_data_i),
        .is_load_i     (is_load_i),
        .load_funct3_i (load_funct3_i),
        .load_addr_lo_i(load_addr_lo_i),
        .dbus_rvalid_i (dbus_rvalid_i),
        .dbus_rdata_i  (dbus_rdata_i),
        .stall_o       (stall_o),
        .w_e_o         (w_e_o),
        .w_addr_o      (w_addr_o),
        .w_data_o      (w_data_o),
        .err_o         (err_o)
    );

    task automatic cycle();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = 0; w_e_i = 0; is_load_i = 0; w_addr_i = 0;
        alu_data_i = $urandom; load_funct3_i = 0; load_addr_lo_i = 0;
        dbus_rvalid_i = 0; dbus_rdata_i = $urandom;
    endtask

    // Returns {write_allowed_by_funct3, extracted_data}.
    function automatic logic [32:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] word);
        logic [31:0] b, h, r;
        b = (word >> (8 * lo)) & 32'hFF;
        h = (word >> (16 * (lo / 2))) & 32'hFFFF;
        case (f3)
            3'd0: begin r = b; if (b >= 128) r = b - 32'd256; return {1'b1, r}; end
            3'd4: return {1'b1, b};
            3'd1: begin r = h; if (h >= 32768) r = h - 32'd65536; return {1'b1, r}; end
            3'd5: return {1'b1, h};
            3'd2: return {1'b1, word};
            default: return {1'b0, 32'd0};
        endcase
    endfunction

    task automatic test_alu_op(input logic we, input logic [4:0] rd, input logic [31:0] data,
                               input string name);
        logic exp_we;
        idle_inputs();
        valid_i = 1; w_e_i = we; w_addr_i = rd; alu_data_i = data;
        dbus_rvalid_i = $urandom;
        cycle();
        exp_we = we && (rd != 0);
        if (exp_we) begin m_addr = rd; m_data = data; end
        idle_inputs();
        checks++;
        if (w_e_o !== exp_we || w_addr_o !== m_addr || w_data_o !== m_data) begin
            errors++;
            $display("FAIL %s_retire: got we=%b addr=%0d data=%h, exp we=%b addr=%0d data=%h",
                     name, w_e_o, w_addr_o, w_data_o, exp_we, m_addr, m_data);
        end
        cycle();
        checks++;
        if (w_e_o !== 1'b0 || w_addr_o !== m_addr || w_data_o !== m_data || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: got we=%b addr=%0d data=%h stall=%b, exp we=0 addr=%0d data=%h stall=0",
                     name, w_e_o, w_addr_o, w_data_o, stall_o, m_addr, m_data);
        end
    endtask

    task automatic test_load_op(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                                input logic we, input logic [31:0] word, input int gap,
                                input string name);
        logic [32:0] ref_v;
        logic        exp_we;
        ref_v  = ref_load(f3, lo, word);
        exp_we = ref_v[32] && we && (rd != 0);
        idle_inputs();
        valid_i = 1; is_load_i = 1; w_e_i = we; w_addr_i = rd;
        load_funct3_i = f3; load_addr_lo_i = lo;
        cycle();
        checks++;
        if (w_e_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept_we: got %b exp 0", name, w_e_o);
        end
        for (int i = 0; i < gap; i++) begin
            checks++;
            if (stall_o !== 1'b1) begin
                errors++;
                $display("FAIL %s_stall[%0d]: got %b exp 1", name, i, stall_o);
            end
            // Noise on the upstream inputs while waiting must not matter.
            valid_i = $urandom; is_load_i = $urandom; w_e_i = 1;
            w_addr_i = 5'($urandom_range(1, 31)); alu_data_i = $urandom;
            load_funct3_i = 3'($urandom); load_addr_lo_i = 2'($urandom);
            dbus_rvalid_i = (i == gap - 1);
            dbus_rdata_i  = (i == gap - 1) ? word : $urandom;
            cycle();
        end
        idle_inputs();
        if (exp_we) begin m_addr = rd; m_data = ref_v[31:0]; end
        checks++;
        if (stall_o !== 1'b0 || w_e_o !== exp_we || w_addr_o !== m_addr || w_data_o !== m_data) begin
            errors++;
            $display("FAIL %s_retire: got stall=%b we=%b addr=%0d data=%h, exp stall=0 we=%b addr=%0d data=%h",
                     name, stall_o, w_e_o, w_addr_o, w_data_o, exp_we, m_addr, m_data);
        end
        cycle();
        checks++;
        if (w_e_o !== 1'b0 || w_data_o !== m_data) begin
            errors++;
            $display("FAIL %s_pulse: got we=%b data=%h, exp we=0 data=%h", name, w_e_o, w_data_o, m_data);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        srst = 1; valid_i = 1; w_e_i = 1; w_addr_i = 7; dbus_rvalid_i = 1;
        cycle(); cycle();
        m_addr = 0; m_data = 0;
        checks++;
        if (stall_o !== 0 || w_e_o !== 0 || w_addr_o !== 0 || w_data_o !== 0 || err_o !== 0) begin
            errors++;
            $display("FAIL reset_state: got stall=%b we=%b addr=%0d data=%h err=%b, exp all 0",
                     stall_o, w_e_o, w_addr_o, w_data_o, err_o);
        end
        srst = 0; idle_inputs();
        dbus_rvalid_i = 1; dbus_rdata_i = 32'hDEADBEEF;
        cycle();
        checks++;
        if (stall_o !== 0 || w_e_o !== 0 || w_data_o !== 0) begin
            errors++;
            $display("FAIL stale_rvalid: got stall=%b we=%b data=%h, exp 0 0 0", stall_o, w_e_o, w_data_o);
        end
        idle_inputs();
    endtask

    task automatic test_directed();
        test_alu_op(1, 5'd5, 32'h12345678, "alu");
        test_load_op(3'b000, 2'd3, 5'd9,  1, 32'h80FFFFFF, 2, "lb");
        test_load_op(3'b100, 2'd3, 5'd10, 1, 32'h80FFFFFF, 2, "lbu");
        test_load_op(3'b101, 2'd2, 5'd11, 1, 32'hBEEF1234, 1, "lhu");
        test_load_op(3'b001, 2'd3, 5'd12, 1, 32'h8001_7FFF, 3, "lh_odd");
        test_alu_op(1, 5'd0, 32'hCAFEF00D, "alu_rd0");
        test_alu_op(0, 5'd6, 32'h0BADF00D, "alu_nowe");
        test_load_op(3'b010, 2'd0, 5'd0,  1, 32'hA5A5A5A5, 1, "lw_rd0");
        test_load_op(3'b011, 2'd0, 5'd13, 1, 32'h11223344, 2, "f3_011");
        test_load_op(3'b111, 2'd1, 5'd14, 1, 32'h55667788, 1, "f3_111");
    endtask

    task automatic test_reset_in_wait();
        idle_inputs();
        valid_i = 1; is_load_i = 1; w_e_i = 1; w_addr_i = 5'd20; load_funct3_i = 3'b010;
        cycle();
        idle_inputs();
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_stall: got %b exp 1", stall_o);
        end
        srst = 1; dbus_rvalid_i = 1; dbus_rdata_i = 32'h76543210;
        cycle();
        srst = 0;
        m_addr = 0; m_data = 0;
        cycle();
        dbus_rvalid_i = 0;
        checks++;
        if (stall_o !== 0 || w_e_o !== 0 || w_addr_o !== 0 || w_data_o !== 0) begin
            errors++;
            $display("FAIL rstwait_after: got stall=%b we=%b addr=%0d data=%h, exp all 0",
                     stall_o, w_e_o, w_addr_o, w_data_o);
        end
        test_alu_op(1, 5'd3, 32'h0000_0042, "rstwait_alu");
    endtask

`ifdef MEM_WB_LOAD_TIMEOUT_EN
    task automatic test_timeout();
        idle_inputs();
        valid_i = 1; is_load_i = 1; w_e_i = 1; w_addr_i = 5'd21; load_funct3_i = 3'b010;
        cycle();
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (stall_o !== 1'b1 || err_o !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait[%0d]: got stall=%b err=%b exp 1 0", i, stall_o, err_o);
            end
            cycle();
        end
        checks++;
        if (stall_o !== 0 || err_o !== 1 || w_e_o !== 0 || w_data_o !== m_data) begin
            errors++;
            $display("FAIL timeout_abort: got stall=%b err=%b we=%b data=%h, exp 0 1 0 %h",
                     stall_o, err_o, w_e_o, w_data_o, m_data);
        end
        test_alu_op(1, 5'd4, 32'h0F0F0F0F, "timeout_alu");
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b exp 1", err_o);
        end
        srst = 1; cycle(); srst = 0;
        m_addr = 0; m_data = 0;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b exp 0", err_o);
        end
    endtask
`else
    task automatic test_no_timeout();
        idle_inputs();
        valid_i = 1; is_load_i = 1; w_e_i = 1; w_addr_i = 5'd22; load_funct3_i = 3'b010;
        cycle();
        idle_inputs();
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (stall_o !== 1'b1 || err_o !== 1'b0) begin
                errors++;
                $display("FAIL nowait_hold[%0d]: got stall=%b err=%b exp 1 0", i, stall_o, err_o);
            end
            cycle();
        end
        dbus_rvalid_i = 1; dbus_rdata_i = 32'h13579BDF;
        cycle();
        idle_inputs();
        m_addr = 5'd22; m_data = 32'h13579BDF;
        checks++;
        if (stall_o !== 0 || w_e_o !== 1 || w_addr_o !== m_addr || w_data_o !== m_data) begin
            errors++;
            $display("FAIL nowait_retire: got stall=%b we=%b addr=%0d data=%h, exp 0 1 %0d %h",
                     stall_o, w_e_o, w_addr_o, w_data_o, m_addr, m_data);
        end
        cycle();
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 0)
                test_alu_op(1'($urandom), 5'($urandom), $urandom, "rnd_alu");
            else
                test_load_op(3'($urandom), 2'($urandom), 5'($urandom), 1'($urandom_range(0, 3) != 0),
                             $urandom, $urandom_range(1, 4), "rnd_ld");
        end
    endtask

    initial begin
        srst = 1;
        idle_inputs();
        m_addr = 0; m_data = 0;
        test_reset();
        test_directed();
        test_reset_in_wait();
`ifdef MEM_WB_LOAD_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
